iiitb_piso_stream: RTL and testbench
====================================

// Module: iiitb_piso_stream
// PURPOSE
// - Parametrised parallel-in/serial-out streamer; next generation of the 8-bit load/shift PISO.
// - Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding buffer.
// - Serialises each word with selectable bit order, frame start/end markers and a downstream stall input.
// - Sits between a user_proj_example-level wrapper (io_in/LA sources) and a serial pad output.
// PARAMETERS
// - WIDTH      8   data word width in bits (>=2)
// - LSB_FIRST  0   0: MSB shifted out first; 1: LSB first
// - CNT_W      16  width of the frame counter
// PORTS
// - clk        in   1      system clock (wb_clk_i at top level)
// - rst        in   1      asynchronous reset, active-low
// - in_valid   in   1      word present on in_data
// - in_data    in   WIDTH  parallel word
// - in_ready   out  1      buffer can accept a word; word accepted on edge with in_valid&in_ready
// - ser_en     in   1      downstream consumes current bit on this edge; 0 = stall
// - ser_out    out  1      serial data bit
// - ser_valid  out  1      ser_out holds a valid bit
// - ser_sof    out  1      current bit is the first of a frame
// - ser_eof    out  1      current bit is the last of a frame
// - busy       out  1      shifter active or holding buffer full
// - frame_cnt  out  CNT_W  completed frames, wraps at 2**CNT_W
// BEHAVIOUR
// - Reset (rst=0, async): all outputs 0 except in_ready=1; shifter, hold buffer, bit counter cleared;
//   a partially sent frame is dropped, not resumed.
// - Storage: shift register + one hold register (hold_full flag). in_ready = ~hold_full (registered flag).
// - FSM: IDLE (ser_valid=0), SHIFT (ser_valid=1). FLEN = WIDTH (WIDTH+1 with parity option).
// - IDLE: accepted word loads the shifter directly; first bit on ser_out the next cycle
//   (1-cycle latency), ser_sof=1; go SHIFT.
// - SHIFT: a bit is consumed on each edge with ser_en=1; bit counter advances 0..FLEN-1.
//   ser_en=0: ser_out/sof/eof/counter frozen, no bit lost or repeated.
// - Word accepted while SHIFT goes to hold register; hold_full set.
// - Last bit (ser_eof=1) consumed: frame_cnt+1; if hold_full, hold moves to shifter
//   and next frame starts the very next cycle (no gap), hold_full cleared;
//   else if in_valid (in_ready=1), that word loads shifter directly, no gap;
//   else go IDLE, ser_valid=0.
// - Hold full and shifter draining same edge: in_ready was 0, so no accept;
//   in_ready returns to 1 the next cycle.
// - WIDTH=... single-bit-per-frame not supported; ser_sof and ser_eof never high together.
// - Bit order: LSB_FIRST=0 sends in_data[WIDTH-1] first; LSB_FIRST=1 sends in_data[0] first.
// - busy = (state==SHIFT) | hold_full.
// CONFIGURATION
// - Macro PISO_PARITY_EN defined: one even-parity bit (XOR of the word) appended after the data bits;
//   FLEN=WIDTH+1; ser_eof flags the parity bit.
// - Not defined: FLEN=WIDTH; ser_eof flags the last data bit; no parity logic synthesised.
// TESTING (WIDTH=8, CNT_W=16, ser_en=1 unless stated)
// - LSB_FIRST=0, send 0xC4 in IDLE -> next cycle ser_out 1,1,0,0,0,1,0,0 over 8 cycles;
//   sof on bit 0, eof on bit 7; frame_cnt=1; then ser_valid=0.
// - LSB_FIRST=1, send 0xC4 -> ser_out 0,0,1,0,0,0,1,1.
// - Back-to-back 0xC4,0x0F,0xFF with in_valid held -> 24 consecutive ser_valid cycles, no gap;
//   in_ready low while hold full; frame_cnt=3.
// - ser_en=0 for 3 cycles at bit 4 of 0xC4 -> ser_out frozen at 0, sof/eof 0; resumes with bit 5;
//   total frame 11 cycles.
// - rst pulsed low at bit 3 with 0x0F held -> all outputs 0, in_ready=1, frame_cnt=0;
//   next send 0xA0 starts fresh with sof.
// - PISO_PARITY_EN, send 0xC4 (3 ones) -> 9 bits, 9th = 1 with eof; 0x0F -> 9th = 0.

Source files
------------

// File: rtl/iiitb_piso_stream.sv
// Parallel-in/serial-out streamer: valid/ready word input, one-word hold buffer,
// framed serial output with stall. Define PISO_PARITY_EN to append an even-parity bit.
module iiitb_piso_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_sof,
    output logic             ser_eof,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int BW = $clog2(FLEN);

    // Handshake: a word moves on a rising edge where in_valid and in_ready are both high;
    // a serial bit moves on a rising edge where ser_valid and ser_en are both high.
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full;
    logic [BW-1:0]    bit_cnt;
    logic [CNT_W-1:0] frame_q;
    logic             accept;
    logic             last_bit;
    logic             data_bit;
    logic             cur_bit;
    logic             load_in;
    logic             load_hold;
    logic             to_hold;
    logic             shift;
    logic             done;

    assign accept   = in_valid & ~hold_full;
    assign last_bit = (state == SHIFT) && (bit_cnt == BW'(FLEN - 1));
    assign data_bit = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];

`ifdef PISO_PARITY_EN
    logic par_q;
    assign cur_bit = (bit_cnt == BW'(WIDTH)) ? par_q : data_bit;
`else
    assign cur_bit = data_bit;
`endif

    always_comb begin
        state_d   = state;
        load_in   = 1'b0;
        load_hold = 1'b0;
        to_hold   = 1'b0;
        shift     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_in = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en) begin
                    if (last_bit) begin
                        done = 1'b1;
                        // Refill from the hold buffer first, then straight from the input, so frames abut.
                        if (hold_full)   load_hold = 1'b1;
                        else if (accept) load_in   = 1'b1;
                        else             state_d   = IDLE;
                    end else begin
                        shift = 1'b1;
                    end
                end
                if (accept && !load_in) to_hold = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sh_q      <= '0;
            hold_q    <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            frame_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (load_in) begin
                sh_q    <= in_data;
                bit_cnt <= '0;
`ifdef PISO_PARITY_EN
                par_q   <= ^in_data;
`endif
            end else if (load_hold) begin
                sh_q    <= hold_q;
                bit_cnt <= '0;
`ifdef PISO_PARITY_EN
                par_q   <= ^hold_q;
`endif
            end else if (shift) begin
                sh_q    <= LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (to_hold) begin
                hold_q    <= in_data;
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            if (done) frame_q <= frame_q + 1'b1;
        end
    end

    assign in_ready  = ~hold_full;
    assign ser_valid = (state == SHIFT);
    assign ser_out   = ser_valid & cur_bit;
    assign ser_sof   = ser_valid && (bit_cnt == '0);
    assign ser_eof   = last_bit;
    assign busy      = ser_valid | hold_full;
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_iiitb_piso_stream.sv
// Directed bench for iiitb_piso_stream: MSB-first and LSB-first instances share stimulus.
module tb_iiitb_piso_stream;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        ser_en;
    logic        in_ready0, ser_out0, ser_valid0, ser_sof0, ser_eof0, busy0;
    logic        in_ready1, ser_out1, ser_valid1, ser_sof1, ser_eof1, busy1;
    logic [15:0] frame_cnt0, frame_cnt1;

    int errors = 0;
    int checks = 0;

    logic [0:0] exp0_q[$];
    logic [0:0] exp1_q[$];

    iiitb_piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .ser_en(ser_en), .ser_out(ser_out0), .ser_valid(ser_valid0), .ser_sof(ser_sof0),
        .ser_eof(ser_eof0), .busy(busy0), .frame_cnt(frame_cnt0)
    );

    iiitb_piso_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .ser_en(ser_en), .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_sof(ser_sof1),
        .ser_eof(ser_eof1), .busy(busy1), .frame_cnt(frame_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected serial bits for one word; par is the hand-computed even parity.
    task automatic push_word(input logic [7:0] w, input logic par);
        for (int i = 0; i < 8; i++) begin
            exp0_q.push_back(w[7-i]);
            exp1_q.push_back(w[i]);
        end
`ifdef PISO_PARITY_EN
        exp0_q.push_back(par);
        exp1_q.push_back(par);
`else
        if (par) begin end
`endif
    endtask

    // Sends one word from IDLE and checks every bit; optional stall while bit stall_at is shown.
    task automatic run_frame(input logic [7:0] w, input logic par, input int stall_at,
                             input int stall_n, input logic [15:0] exp_cnt);
        logic [0:0] e0, e1;
        int cyc;
        cyc = 0;
        push_word(w, par);
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int pos = 0; pos < FLEN; pos++) begin
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            chk($sformatf("frm%02h_valid%0d", w, pos), {31'd0, ser_valid0}, 32'd1);
            chk($sformatf("frm%02h_msb%0d", w, pos), {31'd0, ser_out0}, {31'd0, e0});
            chk($sformatf("frm%02h_lsb%0d", w, pos), {31'd0, ser_out1}, {31'd0, e1});
            chk($sformatf("frm%02h_sof%0d", w, pos), {31'd0, ser_sof0}, {31'd0, pos == 0});
            chk($sformatf("frm%02h_eof%0d", w, pos), {31'd0, ser_eof0}, {31'd0, pos == FLEN-1});
            cyc++;
            if (pos == stall_at) begin
                ser_en = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk($sformatf("stall%0d_msb", s), {31'd0, ser_out0}, {31'd0, e0});
                    chk($sformatf("stall%0d_lsb", s), {31'd0, ser_out1}, {31'd0, e1});
                    chk($sformatf("stall%0d_sof", s), {31'd0, ser_sof0}, 32'd0);
                    chk($sformatf("stall%0d_eof", s), {31'd0, ser_eof0}, 32'd0);
                    if (ser_valid0) cyc++;
                end
                ser_en = 1'b1;
            end
            tick();
        end
        chk($sformatf("frm%02h_len", w), cyc, FLEN + ((stall_at >= 0) ? stall_n : 0));
        chk($sformatf("frm%02h_idle", w), {31'd0, ser_valid0}, 32'd0);
        chk($sformatf("frm%02h_busy", w), {31'd0, busy0}, 32'd0);
        chk($sformatf("frm%02h_cnt0", w), {16'd0, frame_cnt0}, {16'd0, exp_cnt});
        chk($sformatf("frm%02h_cnt1", w), {16'd0, frame_cnt1}, {16'd0, exp_cnt});
    endtask

    initial begin
        logic [7:0] words[3];
        logic [0:0] e0, e1;
        int idx, nv, first_v, last_v;
        logic fire;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ser_en   = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst_valid", {31'd0, ser_valid0}, 32'd0);
        chk("rst_out", {31'd0, ser_out0}, 32'd0);
        chk("rst_sof_eof", {30'd0, ser_sof0, ser_eof0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt0}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Single frame 0xC4: MSB-first 1,1,0,0,0,1,0,0 and LSB-first 0,0,1,0,0,0,1,1.
        run_frame(8'hC4, 1'b1, -1, 0, 16'd1);

        // Back-to-back 0xC4, 0x0F, 0xFF with in_valid held.
        words = '{8'hC4, 8'h0F, 8'hFF};
        push_word(8'hC4, 1'b1);
        push_word(8'h0F, 1'b0);
        push_word(8'hFF, 1'b0);
        idx = 0; nv = 0; first_v = -1; last_v = -1;
        in_data  = words[0];
        in_valid = 1'b1;
        for (int c = 0; c < 3*FLEN + 6; c++) begin
            fire = in_valid & in_ready0;
            tick();
            if (fire) begin
                idx++;
                if (idx == 2) begin
                    chk("b2b_hold_ready", {31'd0, in_ready0}, 32'd0);
                    chk("b2b_hold_busy", {31'd0, busy0}, 32'd1);
                end
                if (idx == 3) in_valid = 1'b0;
                else          in_data  = words[idx];
            end
            if (ser_valid0) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nv++;
                if (exp0_q.size() > 0) begin
                    e0 = exp0_q.pop_front();
                    e1 = exp1_q.pop_front();
                    chk($sformatf("b2b_msb%0d", nv-1), {31'd0, ser_out0}, {31'd0, e0});
                    chk($sformatf("b2b_lsb%0d", nv-1), {31'd0, ser_out1}, {31'd0, e1});
                end
            end
        end
        chk("b2b_words_taken", idx, 3);
        chk("b2b_valid_cycles", nv, 3*FLEN);
        chk("b2b_no_gap", last_v - first_v + 1, 3*FLEN);
        chk("b2b_cnt", {16'd0, frame_cnt0}, 32'd4);
        chk("b2b_ready_end", {31'd0, in_ready0}, 32'd1);
        exp0_q.delete();
        exp1_q.delete();

        // Stall 3 cycles while bit 4 of 0xC4 is on the line.
        run_frame(8'hC4, 1'b1, 4, 3, 16'd5);

        // Reset mid-frame at bit 3 of 0x0F with in_valid held (hold also loaded).
        in_data  = 8'h0F;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_hold", {31'd0, in_ready0}, 32'd0);
        chk("pre_rst_bit3", {31'd0, ser_out0}, 32'd0);
        rst = 1'b0;
        #2;
        chk("mid_rst_in_ready", {31'd0, in_ready0}, 32'd1);
        chk("mid_rst_valid", {31'd0, ser_valid0}, 32'd0);
        chk("mid_rst_out", {30'd0, ser_out0, ser_out1}, 32'd0);
        chk("mid_rst_sof_eof", {30'd0, ser_sof0, ser_eof0}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_cnt", {16'd0, frame_cnt0}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, ser_valid0}, 32'd0);

        // Fresh frame after reset: 0xA0.
        run_frame(8'hA0, 1'b0, -1, 0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
